ram_loader: RTL and testbench

// - Upstream programming sequencer for the 16x8 RAM in programming mode.
// - Accepts bytes over a valid/ready handshake and drives the RAM's dip-switch address, dip-switch data
//   and write_enable_n inputs, which are the programming-side inputs of the RAM.
// - Auto-increments the address and generates a clean, timed active-low write pulse for each byte.
// - Replaces manual switch toggling with a sequenced load of a full program image.

---
 rtl/ram_loader.sv | 149 ++++++++++++++
 tb/tb_ram_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-stream programming sequencer for a small dip-switch RAM
//
// Takes bytes over a valid/ready handshake and walks them into the RAM's
// programming-side inputs. Each byte gets a setup window, a timed active-low
// write pulse and a hold cycle, then the address auto-increments.
//
// Ports:
//   clk         system clock, rising edge
//   clear_n     synchronous active-low reset
//   prog_mode   loader enable (mirrors the RAM prog_mode switch)
//   load_start  1-cycle strobe: load start_addr, clear word_count/done
//   start_addr  start address sampled on load_start
//   data_in     byte to store
//   data_valid  data_in valid
//   data_ready  loader accepts data_in this cycle (combinational)
//   ram_addr    to RAM dipswitch_addr
//   ram_data    to RAM dipswitch_data
//   ram_we_n    to RAM write_enable_n, active low, registered
//   busy        write sequence in progress, registered
//   done        full image written since last load_start/reset, registered
//   word_count  words written since last load_start/reset
module ram_loader #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int SETUP_CYCLES    = 1,
  parameter int WE_PULSE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  prog_mode,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we_n,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]           SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0]           PULSE_LAST = 16'(WE_PULSE_CYCLES - 1);

  state_t              state, state_next;
  logic [15:0]         cnt, cnt_next;
  logic                transfer;
  logic                load;
  logic                advance;
  logic [ADDR_WIDTH:0] count_inc;

  assign data_ready = (state == S_IDLE) & prog_mode & ~load_start;
  assign transfer   = data_ready & data_valid;
  assign count_inc  = word_count + COUNT_ONE;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        // load_start wins over a simultaneous byte; data_ready is already low
        if (load_start) begin
          load = 1'b1;
        end else if (transfer) begin
          state_next = S_SETUP;
          cnt_next   = '0;
        end
      end
      S_SETUP: begin
        // Leaving programming mode before the pulse cancels the byte cleanly
        if (!prog_mode) begin
          state_next = S_IDLE;
        end else if (cnt == SETUP_LAST) begin
          state_next = S_WRITE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_WRITE: begin
        // Once started, the pulse always runs its full width
        if (cnt == PULSE_LAST) begin
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_HOLD: begin
        advance    = 1'b1;
        state_next = (count_inc == FULL_COUNT) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (load_start) begin
          load       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Strobe outputs are decoded from the next state so they change exactly
  // on the state edge and come straight from flops.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we_n   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ram_we_n <= (state_next != S_WRITE);
      busy     <= (state_next == S_SETUP) || (state_next == S_WRITE) || (state_next == S_HOLD);
      done     <= (state_next == S_DONE);
      if (load) begin
        ram_addr   <= start_addr;
        word_count <= '0;
      end
      if (transfer) begin
        ram_data <= data_in;
      end
      if (advance) begin
        ram_addr   <= ram_addr + ADDR_ONE;
        word_count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader
module tb_ram_loader;

  localparam int SC = 1;
  localparam int WP = 1;

  logic       clk = 1'b0;
  logic       clear_n, prog_mode, load_start, data_valid;
  logic [3:0] start_addr;
  logic [7:0] data_in;
  logic       data_ready, ram_we_n, busy, done;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic [4:0] word_count;

  logic       b_clear_n, b_pm, b_ls, b_dv;
  logic [3:0] b_sa;
  logic [7:0] b_d;
  logic       b_dr, b_we_n, b_busy, b_done;
  logic [3:0] b_addr;
  logic [7:0] b_data;
  logic [4:0] b_wc;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .clear_n(clear_n), .prog_mode(prog_mode), .load_start(load_start),
    .start_addr(start_addr), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we_n(ram_we_n), .busy(busy), .done(done), .word_count(word_count)
  );

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SETUP_CYCLES(2), .WE_PULSE_CYCLES(3)) dut2 (
    .clk(clk), .clear_n(b_clear_n), .prog_mode(b_pm), .load_start(b_ls),
    .start_addr(b_sa), .data_in(b_d), .data_valid(b_dv),
    .data_ready(b_dr), .ram_addr(b_addr), .ram_data(b_data),
    .ram_we_n(b_we_n), .busy(b_busy), .done(b_done), .word_count(b_wc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a single timer counting cycles since the byte was accepted
  int unsigned m_t    = 0;
  logic [3:0]  m_addr = 0;
  logic [7:0]  m_data = 0;
  logic [4:0]  m_cnt  = 0;
  logic        m_done = 0;

  always @(posedge clk) begin
    if (!clear_n) begin
      m_t = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_done = 0;
    end else if (m_t == 0) begin
      if (load_start) begin
        m_addr = start_addr; m_cnt = 0; m_done = 0;
      end else if (!m_done && prog_mode && data_valid) begin
        m_data = data_in; m_t = 1;
      end
    end else if (m_t <= SC) begin
      if (!prog_mode) m_t = 0;
      else m_t++;
    end else if (m_t <= SC + WP) begin
      m_t++;
    end else begin
      m_addr++;
      m_cnt++;
      if (m_cnt == 5'd16) m_done = 1;
      m_t = 0;
    end
  end

  function automatic logic model_dr();
    return (m_t == 0) && !m_done && prog_mode && !load_start;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " ram_addr"}, ram_addr, m_addr);
    chk({tag, " ram_data"}, ram_data, m_data);
    chk({tag, " ram_we_n"}, ram_we_n, !(m_t > SC && m_t <= SC + WP));
    chk({tag, " busy"}, busy, m_t != 0);
    chk({tag, " done"}, done, m_done);
    chk({tag, " word_count"}, word_count, m_cnt);
  endtask

  // Write-pulse monitor: records address/data/cycle at each falling edge of ram_we_n
  logic [3:0] p_addr[$];
  logic [7:0] p_data[$];
  int         p_cyc[$];
  int         cyc = 0;
  logic       prev_we = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_we === 1'b1 && ram_we_n === 1'b0) begin
      p_addr.push_back(ram_addr);
      p_data.push_back(ram_data);
      p_cyc.push_back(cyc);
    end
    prev_we = ram_we_n;
  end

  logic last_xfer;

  // dr_mode: 0 = no data_ready check, 1 = against exp_dr, 2 = against the model
  task automatic step(input logic cn, input logic pm, input logic ls, input logic [3:0] sa,
                      input logic [7:0] d, input logic dv, input int dr_mode, input logic exp_dr);
    @(negedge clk);
    clear_n = cn; prog_mode = pm; load_start = ls; start_addr = sa; data_in = d; data_valid = dv;
    #1;
    last_xfer = cn && dv && model_dr();
    if (dr_mode == 1) chk("data_ready", data_ready, exp_dr);
    else if (dr_mode == 2) chk("model data_ready", data_ready, model_dr());
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic cn, pm, ls; logic [3:0] sa; logic [7:0] d; logic dv;
    int   drm; logic dr;
    logic [3:0] addr; logic [7:0] data; logic we, bsy, dn; logic [4:0] wc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] nb;
    int sent;
    logic we_exp[7];
    logic busy_exp[7];
    logic [3:0] addr_exp[7];

    clear_n = 0; prog_mode = 0; load_start = 0; start_addr = 0; data_in = 0; data_valid = 0;
    b_clear_n = 0; b_pm = 0; b_ls = 0; b_sa = 0; b_d = 0; b_dv = 0;

    //            cn pm ls sa     d      dv drm dr   addr  data   we bsy dn wc
    vecs.push_back('{0, 1, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 1, 4'hA, 8'h00, 0, 1, 0, 4'hA, 8'h00, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'hCF, 1, 1, 1, 4'hA, 8'hCF, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'hA, 8'hCF, 0, 1, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'hA, 8'hCF, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'hB, 8'hCF, 1, 0, 0, 5'd1});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 1, 4'hB, 8'hCF, 1, 0, 0, 5'd1});
    vecs.push_back('{1, 1, 1, 4'h3, 8'h55, 1, 1, 0, 4'h3, 8'hCF, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 1, 4'h3, 8'hCF, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h77, 1, 1, 1, 4'h3, 8'h77, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'h3, 8'h77, 0, 1, 0, 5'd0});
    vecs.push_back('{0, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'h0, 8'h00, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 1, 4'h0, 8'h00, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h11, 1, 1, 1, 4'h0, 8'h11, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 0, 0, 4'h0, 8'h00, 0, 1, 0, 4'h0, 8'h11, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 1, 4'h0, 8'h11, 1, 0, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h22, 1, 1, 1, 4'h0, 8'h22, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 1, 0, 4'h0, 8'h00, 0, 1, 0, 4'h0, 8'h22, 0, 1, 0, 5'd0});
    vecs.push_back('{1, 0, 0, 4'h0, 8'h00, 0, 1, 0, 4'h0, 8'h22, 1, 1, 0, 5'd0});
    vecs.push_back('{1, 0, 0, 4'h0, 8'h00, 0, 1, 0, 4'h1, 8'h22, 1, 0, 0, 5'd1});
    vecs.push_back('{1, 0, 0, 4'h0, 8'h00, 0, 1, 0, 4'h1, 8'h22, 1, 0, 0, 5'd1});

    foreach (vecs[i]) begin
      step(vecs[i].cn, vecs[i].pm, vecs[i].ls, vecs[i].sa, vecs[i].d, vecs[i].dv, vecs[i].drm, vecs[i].dr);
      chk($sformatf("vec%0d ram_addr", i), ram_addr, vecs[i].addr);
      chk($sformatf("vec%0d ram_data", i), ram_data, vecs[i].data);
      chk($sformatf("vec%0d ram_we_n", i), ram_we_n, vecs[i].we);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d done", i), done, vecs[i].dn);
      chk($sformatf("vec%0d word_count", i), word_count, vecs[i].wc);
    end

    // Full image: 16 bytes streamed back-to-back from address 0
    step(1, 1, 1, 4'h0, 8'h00, 0, 2, 0);
    p_addr.delete(); p_data.delete(); p_cyc.delete();
    nb = 8'h00;
    for (int i = 0; i < 68; i++) begin
      step(1, 1, 0, 4'h0, nb, 1, 2, 0);
      check_model("full");
      if (last_xfer) nb++;
    end
    chk("full pulse count", p_addr.size(), 16);
    for (int i = 0; i < 16 && i < p_addr.size(); i++) begin
      chk($sformatf("full pulse%0d addr", i), p_addr[i], i);
      chk($sformatf("full pulse%0d data", i), p_data[i], i);
      if (i > 0) chk($sformatf("full pulse%0d spacing", i), p_cyc[i] - p_cyc[i-1], 4);
    end
    step(1, 1, 0, 4'h0, 8'hAA, 1, 1, 0);
    chk("full done", done, 1);
    chk("full ram_addr", ram_addr, 0);
    chk("full word_count", word_count, 16);

    // Wrap from 0xE
    step(1, 1, 1, 4'hE, 8'h00, 0, 2, 0);
    p_addr.delete(); p_data.delete(); p_cyc.delete();
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 4'h0, nb, sent < 3, 2, 0);
      if (last_xfer) begin sent++; nb++; end
    end
    chk("wrap pulse count", p_addr.size(), 3);
    if (p_addr.size() == 3) begin
      chk("wrap addr0", p_addr[0], 4'hE);
      chk("wrap addr1", p_addr[1], 4'hF);
      chk("wrap addr2", p_addr[2], 4'h0);
    end
    chk("wrap word_count", word_count, 3);
    chk("wrap done", done, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(7) != 0), ($urandom_range(15) == 0),
           4'($urandom), 8'($urandom), 1'($urandom), 2, 0);
      check_model("rand");
    end

    // Stretched timing: SETUP_CYCLES=2, WE_PULSE_CYCLES=3
    @(negedge clk); b_clear_n = 0;
    @(negedge clk); b_clear_n = 1; b_pm = 1; b_ls = 1; b_sa = 4'h5;
    @(negedge clk); b_ls = 0; b_dv = 1; b_d = 8'h99;
    @(negedge clk); b_dv = 0;
    we_exp   = '{1, 0, 0, 0, 1, 1, 1};
    busy_exp = '{1, 1, 1, 1, 1, 0, 0};
    addr_exp = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h6, 4'h6};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("slow E%0d ram_we_n", k + 1), b_we_n, we_exp[k]);
      chk($sformatf("slow E%0d busy", k + 1), b_busy, busy_exp[k]);
      chk($sformatf("slow E%0d ram_addr", k + 1), b_addr, addr_exp[k]);
      if (k == 2) chk("slow ram_data", b_data, 8'h99);
    end
    chk("slow word_count", b_wc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
